// File: rtl/linebuff_seq_pkg.sv
// linebuff_seq_pkg: shared sequencer state encoding and constants.
// The FLUSH state exists only when LINEBUFF_SEQ_FLUSH_EN is defined.
package linebuff_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    HBLANK = 3'd2,
`ifdef LINEBUFF_SEQ_FLUSH_EN
    FLUSH  = 3'd3,
`endif
    DONE   = 3'd4
  } lbState_e;

  // Number of zero-data strobes appended after the last line.
  localparam int unsigned FLUSH_LEN = 2;

  // Width of the shared blanking/flush cycle counter (H_GAP up to 15).
  localparam int unsigned AUX_W = 4;

endpackage

// File: rtl/linebuff_seq_cnt.sv
// linebuff_seq_cnt: wrap counter with synchronous clear and enable.
// Counts 0..max_i and wraps to 0. wrap_o flags an enabled step taken at max_i.
module linebuff_seq_cnt #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             atMax;

  assign atMax  = (cnt_q == max_i);
  assign wrap_o = en_i & atMax;
  assign cnt_o  = cnt_q;

  // Next count: clear wins, otherwise step or wrap when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = atMax ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/linebuff_seq.sv
// linebuff_seq: turns an upstream valid/ready pixel stream into line-buffer
// write strobes, with H_GAP blanking cycles between lines and frame pulses.
// Define LINEBUFF_SEQ_FLUSH_EN to append a 2-cycle zero-data flush after the
// last line; without it the sequencer goes straight from ACTIVE to DONE.
module linebuff_seq
  import linebuff_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LINE_CNT   = 12,
  parameter int unsigned H_GAP      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LINE_CNT-1:0]   h_size_i,
  input  logic [LINE_CNT-1:0]   v_size_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic                  ce_o,
  output logic [DATA_WIDTH-1:0] data_pixel_o,
  output logic                  first_ln_o,
  output logic                  rd_en_o,
  output logic [LINE_CNT-1:0]   h_size_o,
  output logic                  busy_o,
  output logic                  line_done_o,
  output logic                  frame_done_o
);

  lbState_e              state_q, state_d;
  logic [AUX_W-1:0]      aux_q, aux_d;
  logic [LINE_CNT-1:0]   hSize_q, hSize_d;
  logic [LINE_CNT-1:0]   vSize_q, vSize_d;
  logic                  ce_q, ce_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  first_q, first_d;
  logic                  rd_q, rd_d;
  logic                  lineDone_q, lineDone_d;
  logic                  frameDone_q, frameDone_d;

  logic                  xfer;
  logic                  startAcc;
  logic                  pixWrap;
  logic                  lineWrap;
  logic [LINE_CNT-1:0]   pixMax;
  logic [LINE_CNT-1:0]   lineMax;
  logic [LINE_CNT-1:0]   lineCnt;
  // Only the pixel counter's wrap is needed; its position is not used.
  logic [LINE_CNT-1:0]   unusedPixCnt;

  assign xfer     = s_valid_i & (state_q == ACTIVE);
  assign startAcc = start_i & (state_q == IDLE);
  assign pixMax   = hSize_q - LINE_CNT'(1);
  assign lineMax  = vSize_q - LINE_CNT'(1);

  linebuff_seq_cnt #(.WIDTH(LINE_CNT)) u_pixCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (startAcc),
    .en_i   (xfer),
    .max_i  (pixMax),
    .cnt_o  (unusedPixCnt),
    .wrap_o (pixWrap)
  );

  linebuff_seq_cnt #(.WIDTH(LINE_CNT)) u_lineCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (startAcc),
    .en_i   (pixWrap),
    .max_i  (lineMax),
    .cnt_o  (lineCnt),
    .wrap_o (lineWrap)
  );

  // Next-state and registered-output decode for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    aux_d       = aux_q;
    hSize_d     = hSize_q;
    vSize_d     = vSize_q;
    ce_d        = xfer;
    data_d      = xfer ? s_data_i : '0;
    first_d     = xfer & (lineCnt == '0);
    rd_d        = xfer & (lineCnt != '0);
    lineDone_d  = pixWrap;
    frameDone_d = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          hSize_d = h_size_i;
          vSize_d = v_size_i;
          aux_d   = '0;
          if ((h_size_i != '0) && (v_size_i != '0)) begin
            state_d = ACTIVE;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACTIVE: begin
        if (pixWrap) begin
          aux_d = '0;
          if (lineWrap) begin
`ifdef LINEBUFF_SEQ_FLUSH_EN
            state_d = FLUSH;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = HBLANK;
          end
        end
      end
      HBLANK: begin
        if (aux_q == AUX_W'(H_GAP - 1)) begin
          aux_d   = '0;
          state_d = ACTIVE;
        end else begin
          aux_d = aux_q + AUX_W'(1);
        end
      end
`ifdef LINEBUFF_SEQ_FLUSH_EN
      FLUSH: begin
        ce_d    = 1'b1;
        rd_d    = 1'b1;
        first_d = 1'b0;
        data_d  = '0;
        if (aux_q == AUX_W'(FLUSH_LEN - 1)) begin
          aux_d   = '0;
          state_d = DONE;
        end else begin
          aux_d = aux_q + AUX_W'(1);
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aux_q       <= '0;
      hSize_q     <= '0;
      vSize_q     <= '0;
      ce_q        <= 1'b0;
      data_q      <= '0;
      first_q     <= 1'b0;
      rd_q        <= 1'b0;
      lineDone_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aux_q       <= aux_d;
      hSize_q     <= hSize_d;
      vSize_q     <= vSize_d;
      ce_q        <= ce_d;
      data_q      <= data_d;
      first_q     <= first_d;
      rd_q        <= rd_d;
      lineDone_q  <= lineDone_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign s_ready_o    = (state_q == ACTIVE);
  assign busy_o       = (state_q != IDLE);
  assign ce_o         = ce_q;
  assign data_pixel_o = data_q;
  assign first_ln_o   = first_q;
  assign rd_en_o      = rd_q;
  assign h_size_o     = hSize_q;
  assign line_done_o  = lineDone_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: doc/linebuff_seq.md
LINEBUFF_SEQ -- requirements
Module: linebuff_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits SHALL be provided.
REQ-002 Parameter LINE_CNT, default 12, width of the pixel/line counters and size inputs SHALL be provided.
REQ-003 Parameter H_GAP, default 2, number of horizontal-blank cycles between lines (range 1..15) SHALL be provided.
REQ-004 Ports SHALL be, clock and reset first:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  reset, synchronous, active-low
  start_i  in  1  frame start request, single-cycle pulse
  h_size_i  in  LINE_CNT  pixels per line, sampled on accepted start
  v_size_i  in  LINE_CNT  lines per frame, sampled on accepted start
  s_valid_i  in  1  upstream pixel valid
  s_data_i  in  DATA_WIDTH  upstream pixel
  s_ready_o  out  1  upstream ready
  ce_o  out  1  line-buffer clock enable, one per accepted pixel
  data_pixel_o  out  DATA_WIDTH  pixel to line buffer
  first_ln_o  out  1  high while driving line 0
  rd_en_o  out  1  high while driving lines 1..v_size-1
  h_size_o  out  LINE_CNT  latched h_size for line buffer
  busy_o  out  1  high in any state except IDLE
  line_done_o  out  1  one-cycle pulse after last pixel of each line
  frame_done_o  out  1  one-cycle pulse at frame end

Function
REQ-005 FSM states SHALL be IDLE, ACTIVE, HBLANK, FLUSH, DONE.
REQ-006 IDLE->ACTIVE on start_i with both sizes nonzero; IDLE->DONE on start_i with either size zero; start_i SHALL be ignored outside IDLE.
REQ-007 s_ready_o SHALL be 1 only in ACTIVE; transfer = s_valid_i & s_ready_o.
REQ-008 Every transfer SHALL produce ce_o=1 with data_pixel_o=s_data_i exactly one cycle later (registered, latency 1); ce_o=0 otherwise.
REQ-009 first_ln_o and rd_en_o SHALL be registered alongside ce_o, reflecting the line index of that pixel; both 0 when ce_o=0.
REQ-010 Pixel counter SHALL increment per transfer and wrap to 0 at h_size-1; on wrap line counter SHALL increment and line_done_o SHALL pulse in the following cycle.
REQ-011 On wrap of a non-final line ACTIVE->HBLANK; HBLANK SHALL last exactly H_GAP cycles then return to ACTIVE.
REQ-012 On wrap of line v_size-1 ACTIVE->FLUSH (macro enabled) or ACTIVE->DONE (disabled).
REQ-013 DONE SHALL last one cycle, pulse frame_done_o, then go to IDLE.
REQ-014 s_valid_i deassertion in ACTIVE SHALL stall counters without state change; no timeout.
REQ-015 h_size_o SHALL hold the latched h_size_i from start acceptance until the next accepted start.
REQ-016 Counter arithmetic SHALL be LINE_CNT bits unsigned; sizes of 2^LINE_CNT-1 SHALL be supported without overflow.

Reset
REQ-017 On rst_n=0 at a clock edge: state IDLE, counters 0, all outputs 0 including h_size_o and data_pixel_o; applies mid-frame with no pulse on line_done_o/frame_done_o.

Configuration
REQ-018 Macro LINEBUFF_SEQ_FLUSH_EN defined: FLUSH SHALL assert ce_o for exactly 2 consecutive cycles with data_pixel_o=0, first_ln_o=0, rd_en_o=1, s_ready_o=0, then go to DONE.
REQ-019 Macro undefined: FLUSH state and its logic SHALL be absent; ACTIVE goes directly to DONE.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding (3-bit enum) and the FLUSH length constant (2).
REQ-021 One sub-module, linebuff_seq_cnt (parameterised wrap counter with enable, wrap flag output), SHALL be instantiated for pixel and line counters.

Verification
REQ-022 h=4,v=3, s_valid_i always 1, start pulse -> 12 ce_o pulses; first_ln_o on pixels 0-3; rd_en_o on 4-11; 2-cycle gaps between lines; 3 line_done_o; 1 frame_done_o.
REQ-023 h=4,v=2, s_valid_i toggling 1010... -> ce_o pulses every other cycle, data order preserved, 8 pulses total.
REQ-024 Start with h=0,v=5 -> frame_done_o pulse 2 cycles after start, zero ce_o, busy_o high 1 cycle.
REQ-025 rst_n low after 5th pixel of h=4,v=3 frame -> next cycle all outputs 0, state IDLE; new start runs full frame correctly.
REQ-026 Start_i pulsed during ACTIVE with different sizes -> ignored, h_size_o unchanged.
REQ-027 LINEBUFF_SEQ_FLUSH_EN defined, h=2,v=2 -> 4 pixel ce_o pulses then 2 flush pulses with data 0, rd_en_o=1, then frame_done_o.
